// File: rtl/ant_power_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ant_power_sched_pkg
//  Description : Shared definitions for the antenna power scheduler:
//                ceil-log2 helper, accumulator width derivation and the
//                sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ant_power_sched_pkg;

    // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Sum of NUM_SAMP unsigned 2*DW-bit terms needs clog2(NUM_SAMP) extra bits.
    function automatic int acc_width(input int dw, input int ns);
        return 2 * dw + clog2(ns);
    endfunction

    localparam int         ST_WIDTH = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ant_power_sched_magnitude.sv
`default_nettype none
// ============================================================================
//  Module      : ant_power_sched_magnitude
//  Description : Combinational |h|^2 = re^2 + im^2 of a signed complex
//                sample. The result is unsigned so the full-scale value
//                2^(2W-1) (both parts at the most negative code) is exact.
//  Ports       : i_real, i_imag - signed DATA_WIDTH coefficient parts
//                o_mag          - unsigned 2*DATA_WIDTH magnitude squared
//  Revision    : 1.0 - initial release
// ============================================================================
module ant_power_sched_magnitude #(
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [DATA_WIDTH-1:0]   i_real,
    input  logic signed [DATA_WIDTH-1:0]   i_imag,
    output logic        [2*DATA_WIDTH-1:0] o_mag
);

    logic signed [2*DATA_WIDTH-1:0] w_re_ext;
    logic signed [2*DATA_WIDTH-1:0] w_im_ext;
    logic signed [2*DATA_WIDTH-1:0] w_re_sq;
    logic signed [2*DATA_WIDTH-1:0] w_im_sq;

    assign w_re_ext = {{DATA_WIDTH{i_real[DATA_WIDTH-1]}}, i_real};
    assign w_im_ext = {{DATA_WIDTH{i_imag[DATA_WIDTH-1]}}, i_imag};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    // Each square is at most 2^(2W-2), so the unsigned sum cannot wrap.
    assign o_mag = $unsigned(w_re_sq) + $unsigned(w_im_sq);

endmodule
`default_nettype wire

// File: rtl/ant_power_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ant_power_sched
//  Description : Walks the channel-coefficient buffer antenna-major, sums
//                |h|^2 per antenna, emits each antenna's power and finally
//                the strongest antenna (ties keep the lower index).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start / busy / done - run control and status
//                rd_en, rd_addr      - coefficient RAM read request
//                rd_real, rd_imag    - read data, one cycle after rd_en
//                pwr_valid/ant/data  - per-antenna power result strobe
//                best_ant, best_pwr  - argmax, held until next run starts
//  Revision    : 1.0 - initial release
// ============================================================================
module ant_power_sched
    import ant_power_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ANT     = 4,
    parameter int NUM_SAMP    = 16,
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, NUM_SAMP),
    localparam int ADDR_WIDTH = clog2(NUM_ANT * NUM_SAMP),
    localparam int ANT_WIDTH  = clog2(NUM_ANT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic signed [DATA_WIDTH-1:0] rd_real,
    input  logic signed [DATA_WIDTH-1:0] rd_imag,
    output logic                         pwr_valid,
    output logic [ANT_WIDTH-1:0]         pwr_ant,
    output logic [ACC_WIDTH-1:0]         pwr_data,
    output logic                         done,
    output logic [ANT_WIDTH-1:0]         best_ant,
    output logic [ACC_WIDTH-1:0]         best_pwr
);

    localparam int SAMP_WIDTH = clog2(NUM_SAMP);
    localparam int MAG_WIDTH  = 2 * DATA_WIDTH;

    localparam logic [SAMP_WIDTH-1:0] c_SAMP_LAST = SAMP_WIDTH'(NUM_SAMP - 1);
    localparam logic [ANT_WIDTH-1:0]  c_ANT_LAST  = ANT_WIDTH'(NUM_ANT - 1);

    logic [ST_WIDTH-1:0]   r_state;
    logic [SAMP_WIDTH-1:0] r_samp;
    logic [ANT_WIDTH-1:0]  r_ant;

    // Tag travelling alongside each outstanding read.
    logic                  r_tag_valid;
    logic                  r_tag_first;
    logic                  r_tag_last;
    logic [ANT_WIDTH-1:0]  r_tag_ant;

    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_pwr_valid;
    logic [ANT_WIDTH-1:0]  r_pwr_ant;
    logic [ACC_WIDTH-1:0]  r_pwr_data;
    logic [ANT_WIDTH-1:0]  r_best_ant;
    logic [ACC_WIDTH-1:0]  r_best_pwr;

    logic [MAG_WIDTH-1:0]  w_mag;
    logic [ACC_WIDTH-1:0]  w_mag_ext;
    logic [ACC_WIDTH-1:0]  w_acc_base;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic                  w_samp_last;
    logic                  w_last_read;

    ant_power_sched_magnitude #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_magnitude (
        .i_real (rd_real),
        .i_imag (rd_imag),
        .o_mag  (w_mag)
    );

    assign w_mag_ext   = {{(ACC_WIDTH - MAG_WIDTH){1'b0}}, w_mag};
    // First sample of an antenna loads rather than adds.
    assign w_acc_base  = r_tag_first ? '0 : r_acc;
    assign w_sum       = w_acc_base + w_mag_ext;
    assign w_samp_last = (r_samp == c_SAMP_LAST);
    assign w_last_read = w_samp_last && (r_ant == c_ANT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_samp      <= '0;
            r_ant       <= '0;
            r_tag_valid <= 1'b0;
            r_tag_first <= 1'b0;
            r_tag_last  <= 1'b0;
            r_tag_ant   <= '0;
            r_acc       <= '0;
            r_pwr_valid <= 1'b0;
            r_pwr_ant   <= '0;
            r_pwr_data  <= '0;
            r_best_ant  <= '0;
            r_best_pwr  <= '0;
        end else begin
            r_pwr_valid <= 1'b0;

            r_tag_valid <= (r_state == ST_READ);
            r_tag_first <= (r_samp == '0);
            r_tag_last  <= w_samp_last;
            r_tag_ant   <= r_ant;

            if (r_tag_valid) begin
                if (r_tag_last) begin
                    r_pwr_valid <= 1'b1;
                    r_pwr_ant   <= r_tag_ant;
                    r_pwr_data  <= w_sum;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_sum;
                end
            end

            // Strict compare: an equal later antenna never displaces the incumbent.
            if (r_pwr_valid && (r_pwr_data > r_best_pwr)) begin
                r_best_ant <= r_pwr_ant;
                r_best_pwr <= r_pwr_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_READ;
                        r_samp     <= '0;
                        r_ant      <= '0;
                        r_best_ant <= '0;
                        r_best_pwr <= '0;
                    end
                end
                ST_READ: begin
                    // NUM_SAMP is a power of two, so the sample counter wraps itself.
                    r_samp <= r_samp + 1'b1;
                    if (w_samp_last) begin
                        r_ant <= (r_ant == c_ANT_LAST) ? '0 : r_ant + 1'b1;
                    end
                    if (w_last_read) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave once the final antenna's result is being compared.
                    if (r_pwr_valid && (r_pwr_ant == c_ANT_LAST)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign rd_en     = (r_state == ST_READ);
    assign rd_addr   = {r_ant, r_samp};
    assign done      = (r_state == ST_DONE);
    assign pwr_valid = r_pwr_valid;
    assign pwr_ant   = r_pwr_ant;
    assign pwr_data  = r_pwr_data;
    assign best_ant  = r_best_ant;
    assign best_pwr  = r_best_pwr;

endmodule
`default_nettype wire

// File: tb/tb_ant_power_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ant_power_sched
//  Description : Self-checking bench for ant_power_sched with
//                DATA_WIDTH=16, NUM_ANT=4, NUM_SAMP=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ant_power_sched;

    localparam int DW = 16;
    localparam int NA = 4;
    localparam int NS = 4;
    localparam int T  = NA * NS;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic                 rd_en;
    logic [3:0]           rd_addr;
    logic signed [DW-1:0] rd_real;
    logic signed [DW-1:0] rd_imag;
    logic                 pwr_valid;
    logic [1:0]           pwr_ant;
    logic [33:0]          pwr_data;
    logic                 done;
    logic [1:0]           best_ant;
    logic [33:0]          best_pwr;

    ant_power_sched #(
        .DATA_WIDTH (DW),
        .NUM_ANT    (NA),
        .NUM_SAMP   (NS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_real   (rd_real),
        .rd_imag   (rd_imag),
        .pwr_valid (pwr_valid),
        .pwr_ant   (pwr_ant),
        .pwr_data  (pwr_data),
        .done      (done),
        .best_ant  (best_ant),
        .best_pwr  (best_pwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient RAM: one-cycle read latency; junk when no read was issued.
    logic signed [DW-1:0] mem_re [T];
    logic signed [DW-1:0] mem_im [T];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_real <= mem_re[rd_addr];
            rd_imag <= mem_im[rd_addr];
        end else begin
            rd_real <= 16'sh7ABC;
            rd_imag <= -16'sd1234;
        end
    end

    typedef struct packed {
        logic              ramp;   // sample value = its own address, imag 0
        logic              ign;    // pulse start in cycles 5 and T+3
        logic [3:0][15:0]  re;     // per-antenna constant sample
        logic [3:0][15:0]  im;
        logic [3:0][33:0]  pwr;    // expected per-antenna power
        logic [1:0]        best;
        logic [33:0]       bpwr;
    } vec_t;

    vec_t vec [5];
    int   n_pass;
    int   n_total;
    int   cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_total++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic load(input int idx);
        for (int a = 0; a < NA; a++) begin
            for (int s = 0; s < NS; s++) begin
                if (vec[idx].ramp) begin
                    mem_re[a*NS+s] = 16'(a*NS + s);
                    mem_im[a*NS+s] = '0;
                end else begin
                    mem_re[a*NS+s] = vec[idx].re[a];
                    mem_im[a*NS+s] = vec[idx].im[a];
                end
            end
        end
    endtask

    // Entered at the falling edge of cycle 0; returns at the falling edge
    // of cycle T+4, the earliest cycle a new start may be accepted.
    task automatic run_check(input int idx);
        logic exp_pv;
        int   a;
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= T + 4; k++) begin
            cyc   = k;
            start = vec[idx].ign && (k == 5 || k == T + 3);
            if (k <= T + 3) begin
                chk("rd_en", {63'd0, rd_en}, {63'd0, k <= T});
                if (k <= T) chk("rd_addr", {60'd0, rd_addr}, 64'(k - 1));
                chk("busy", {63'd0, busy}, {63'd0, k <= T + 2});
                chk("done", {63'd0, done}, {63'd0, k == T + 3});
                exp_pv = (k >= NS + 2) && (k <= T + 2) && (((k - 2) % NS) == 0);
                chk("pwr_valid", {63'd0, pwr_valid}, {63'd0, exp_pv});
                if (exp_pv) begin
                    a = (k - 2) / NS - 1;
                    chk("pwr_ant", {62'd0, pwr_ant}, 64'(a));
                    chk("pwr_data", {30'd0, pwr_data}, {30'd0, vec[idx].pwr[a]});
                end
                if (k == 1) chk("best_pwr_clear", {30'd0, best_pwr}, 64'd0);
            end else begin
                chk("busy_idle", {63'd0, busy}, 64'd0);
                chk("done_idle", {63'd0, done}, 64'd0);
            end
            if (k >= T + 3) begin
                chk("best_ant", {62'd0, best_ant}, {62'd0, vec[idx].best});
                chk("best_pwr", {30'd0, best_pwr}, {30'd0, vec[idx].bpwr});
            end
            if (k < T + 4) @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      {63'd0, busy},      64'd0);
        chk({tag, "_rd_en"},     {63'd0, rd_en},     64'd0);
        chk({tag, "_rd_addr"},   {60'd0, rd_addr},   64'd0);
        chk({tag, "_pwr_valid"}, {63'd0, pwr_valid}, 64'd0);
        chk({tag, "_pwr_ant"},   {62'd0, pwr_ant},   64'd0);
        chk({tag, "_pwr_data"},  {30'd0, pwr_data},  64'd0);
        chk({tag, "_done"},      {63'd0, done},      64'd0);
        chk({tag, "_best_ant"},  {62'd0, best_ant},  64'd0);
        chk({tag, "_best_pwr"},  {30'd0, best_pwr},  64'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        rst     = 1'b1;
        start   = 1'b0;
        for (int i = 0; i < T; i++) begin
            mem_re[i] = '0;
            mem_im[i] = '0;
        end

        // Vector table: per-antenna constant samples and hand-computed results.
        for (int i = 0; i < 5; i++) vec[i] = '0;
        // 0: uniform (3,4) -> 25*4 = 100 everywhere, tie keeps antenna 0
        for (int a = 0; a < NA; a++) begin
            vec[0].re[a] = 16'd3;  vec[0].im[a] = 16'd4;  vec[0].pwr[a] = 34'd100;
        end
        vec[0].ign = 1'b1; vec[0].best = 2'd0; vec[0].bpwr = 34'd100;
        // 1: single peak on antenna 2, (1,-1) -> 2*4 = 8
        vec[1].re[2] = 16'd1; vec[1].im[2] = 16'hFFFF; vec[1].pwr[2] = 34'd8;
        vec[1].best = 2'd2; vec[1].bpwr = 34'd8;
        // 2: full scale (-32768,-32768) -> 2^31 per sample, 2^33 total
        for (int a = 0; a < NA; a++) begin
            vec[2].re[a] = 16'h8000; vec[2].im[a] = 16'h8000;
            vec[2].pwr[a] = 34'h2_0000_0000;
        end
        vec[2].best = 2'd0; vec[2].bpwr = 34'h2_0000_0000;
        // 3: 16, 36, 36, 8 -> later max replaces, equal later one does not
        vec[3].re[0] = 16'd2;     vec[3].im[0] = 16'd0;     vec[3].pwr[0] = 34'd16;
        vec[3].re[1] = 16'd0;     vec[3].im[1] = 16'hFFFD;  vec[3].pwr[1] = 34'd36;
        vec[3].re[2] = 16'hFFFD;  vec[3].im[2] = 16'd0;     vec[3].pwr[2] = 34'd36;
        vec[3].re[3] = 16'd1;     vec[3].im[3] = 16'd1;     vec[3].pwr[3] = 34'd8;
        vec[3].best = 2'd1; vec[3].bpwr = 34'd36;
        // 4: sample = address: sums of squares 0..3, 4..7, 8..11, 12..15
        vec[4].ramp = 1'b1;
        vec[4].pwr[0] = 34'd14;  vec[4].pwr[1] = 34'd126;
        vec[4].pwr[2] = 34'd366; vec[4].pwr[3] = 34'd734;
        vec[4].best = 2'd3; vec[4].bpwr = 34'd734;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back runs: each next start lands in cycle T+4 of the previous.
        for (int i = 0; i < 5; i++) begin
            load(i);
            run_check(i);
        end
        @(negedge clk);

        // Reset in cycle 7 of a run discards everything in flight.
        load(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        cyc = 7;
        rst = 1'b1;
        @(negedge clk);
        cyc = 8;
        chk_all_zero("midrst");
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            cyc = 9 + j;
            chk("midrst_no_pwr_valid", {63'd0, pwr_valid}, 64'd0);
            chk("midrst_no_rd_en", {63'd0, rd_en}, 64'd0);
        end
        load(1);
        run_check(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
